platform_gen: RTL and testbench

- Downstream consumer of the 10-bit LFSR random stream in the jump-game datapath.
- Samples one `rand_num` word per generated platform and maps it to a landing distance and a platform width.
- Distance mapping is a range-reduced modulo done by a multi-cycle FSM.
- Results are buffered in a small prefetch FIFO, so the game-control FSM can pop a new platform with a valid/ready handshake without waiting.

---
 rtl/platform_gen.sv | 172 +++++++++++++++++
 tb/tb_platform_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/platform_gen.sv
// -----------------------------------------------------------------------------
// platform_gen
// Turns the 10-bit LFSR stream into jump-game platforms. For each platform the
// generator samples rand_num once, reduces it modulo DIST_SPAN by repeated
// subtraction, and pushes {distance, width} into a small prefetch FIFO. The
// game-control FSM pops entries with a valid/ready handshake.
//
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset (highest priority)
//   rand_num    LFSR output, read only in the SAMPLE state
//   clear       synchronous flush of FIFO and any generation in flight
//   plat_ready  consumer accepts the head entry
//   plat_valid  FIFO non-empty
//   plat_dist   head entry distance (DIST_MIN + rand mod DIST_SPAN)
//   plat_width  head entry width (WID_MIN + rand[9:8]*WID_STEP)
//   fifo_count  number of stored entries
//   lfsr_stuck  sticky: a sampled rand_num was zero (cleared by rst only)
// -----------------------------------------------------------------------------
module platform_gen #(
    parameter int DIST_MIN  = 40,
    parameter int DIST_SPAN = 100,
    parameter int WID_MIN   = 20,
    parameter int WID_STEP  = 8,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [9:0]               rand_num,
    input  logic                     clear,
    input  logic                     plat_ready,
    output logic                     plat_valid,
    output logic [9:0]               plat_dist,
    output logic [7:0]               plat_width,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     lfsr_stuck
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ONE_I = 1;

    localparam logic [9:0]    SPAN_C   = DIST_SPAN[9:0];
    localparam logic [9:0]    DMIN_C   = DIST_MIN[9:0];
    localparam logic [7:0]    WMIN_C   = WID_MIN[7:0];
    localparam logic [7:0]    WSTEP_C  = WID_STEP[7:0];
    localparam logic [AW:0]   DEPTH_C  = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = ONE_I[AW:0];
    localparam logic [AW-1:0] PTR_ONE  = ONE_I[AW-1:0];

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_REDUCE = 2'd2,
        ST_PUSH   = 2'd3
    } state_t;

    state_t          state_r;
    logic [9:0]      r_r;
    logic [7:0]      w_r;
    logic            stuck_r;

    logic [9:0]      dist_mem_r  [DEPTH];
    logic [7:0]      width_mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [AW:0]     count_r;

    logic [7:0]      wid_s;
    logic            push_s;
    logic            pop_s;

    // Width lookup from the two top rand bits; 8-bit wrap is intended.
    always_comb begin
        wid_s = WMIN_C + ({6'd0, rand_num[9:8]} * WSTEP_C);
    end

    assign push_s     = (state_r == ST_PUSH);
    // A pop request against an empty FIFO is simply ignored.
    assign pop_s      = (count_r != {(AW+1){1'b0}}) && plat_ready;
    assign plat_valid = (count_r != {(AW+1){1'b0}});
    assign plat_dist  = dist_mem_r[rd_ptr_r];
    assign plat_width = width_mem_r[rd_ptr_r];
    assign fifo_count = count_r;
    assign lfsr_stuck = stuck_r;

    // Generator FSM: sample once, subtract DIST_SPAN until in range, then push.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            r_r     <= 10'd0;
            w_r     <= 8'd0;
            stuck_r <= 1'b0;
        end else if (clear) begin
            // Abort in-flight work; the stuck flag survives a flush.
            state_r <= ST_IDLE;
            r_r     <= 10'd0;
            w_r     <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // Only start when a slot is free, so PUSH can never overflow.
                    if (count_r < DEPTH_C) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SAMPLE: begin
                    r_r     <= rand_num;
                    w_r     <= wid_s;
                    if (rand_num == 10'd0) begin
                        stuck_r <= 1'b1;
                    end else begin
                        stuck_r <= stuck_r;
                    end
                    state_r <= ST_REDUCE;
                end
                ST_REDUCE: begin
                    if (r_r >= SPAN_C) begin
                        r_r     <= r_r - SPAN_C;
                        state_r <= ST_REDUCE;
                    end else begin
                        state_r <= ST_PUSH;
                    end
                end
                ST_PUSH: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Prefetch FIFO storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                dist_mem_r[i]  <= 10'd0;
                width_mem_r[i] <= 8'd0;
            end
        end else if (clear) begin
            // Any pop presented together with clear is dropped.
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                dist_mem_r[wr_ptr_r]  <= DMIN_C + r_r;
                width_mem_r[wr_ptr_r] <= w_r;
                wr_ptr_r              <= wr_ptr_r + PTR_ONE;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_platform_gen.sv
// -----------------------------------------------------------------------------
// tb_platform_gen
// Self-checking bench for platform_gen. A transaction-level model keeps the
// expected FIFO contents in a queue; each generated platform is derived from
// the sampled value with plain modulo/division, and the generator timing is
// tracked as "cycles of work remaining" after each sample.
// -----------------------------------------------------------------------------
module tb_platform_gen;

    localparam int DIST_MIN  = 40;
    localparam int DIST_SPAN = 100;
    localparam int WID_MIN   = 20;
    localparam int WID_STEP  = 8;
    localparam int DEPTH     = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] rand_num;
    logic       clear;
    logic       plat_ready;
    logic       plat_valid;
    logic [9:0] plat_dist;
    logic [7:0] plat_width;
    logic [2:0] fifo_count;
    logic       lfsr_stuck;

    int errs   = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0] d;
        logic [7:0] w;
    } ent_t;

    ent_t mq[$];
    bit   m_samp;
    int   m_left;
    bit   m_stuck;
    ent_t m_pend;

    platform_gen #(
        .DIST_MIN(DIST_MIN), .DIST_SPAN(DIST_SPAN), .WID_MIN(WID_MIN),
        .WID_STEP(WID_STEP), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rand_num(rand_num), .clear(clear),
        .plat_ready(plat_ready), .plat_valid(plat_valid), .plat_dist(plat_dist),
        .plat_width(plat_width), .fifo_count(fifo_count), .lfsr_stuck(lfsr_stuck)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic ent_t map_val(input int v);
        ent_t e;
        e.d = 10'(DIST_MIN + (v % DIST_SPAN));
        e.w = 8'(WID_MIN + (v / 256) * WID_STEP);
        return e;
    endfunction

    // Advance the reference model by one cycle using the current inputs.
    task automatic model_step();
        int  sz;
        bit  do_pop;
        bit  do_push;
        int  v;
        if (rst) begin
            mq.delete(); m_samp = 1'b0; m_left = 0; m_stuck = 1'b0;
            return;
        end
        if (clear) begin
            mq.delete(); m_samp = 1'b0; m_left = 0;
            return;
        end
        sz      = mq.size();
        do_pop  = (sz != 0) && plat_ready;
        do_push = 1'b0;
        if (m_samp) begin
            v = int'(rand_num);
            if (v == 0) m_stuck = 1'b1;
            m_pend = map_val(v);
            m_left = v / DIST_SPAN + 2;   // reduce cycles + push cycle
            m_samp = 1'b0;
        end else if (m_left > 0) begin
            if (m_left == 1) do_push = 1'b1;
            m_left--;
        end else if (sz < DEPTH) begin
            m_samp = 1'b1;
        end
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back(m_pend);
    endtask

    // One clock: update the model, then land 1ns after the rising edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; clear = 1'b0; plat_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rand_num = 10'd5;
        do_reset();
        checks++; if (plat_valid !== 1'b0) begin errs++; $display("FAIL reset_valid got %b exp 0", plat_valid); end
        checks++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        checks++; if (lfsr_stuck !== 1'b0) begin errs++; $display("FAIL reset_stuck got %b exp 0", lfsr_stuck); end
        checks++; if (plat_dist !== 10'd0 || plat_width !== 8'd0) begin errs++;
            $display("FAIL reset_head got %0d/%0d exp 0/0", plat_dist, plat_width); end
    endtask

    task automatic test_first_entry();
        int n;
        rand_num = 10'd250;
        do_reset();
        // Cycle 0 is IDLE, cycle 1 SAMPLE, entry visible at cycle 6.
        for (int t = 0; t <= 6; t++) begin
            checks++;
            if (plat_valid !== 1'(t == 6)) begin errs++;
                $display("FAIL first_valid cycle=%0d got %b exp %b", t, plat_valid, (t == 6)); end
            if (t < 6) tick();
        end
        checks++; if (plat_dist !== 10'd90 || plat_width !== 8'd20) begin errs++;
            $display("FAIL first_head got %0d/%0d exp 90/20", plat_dist, plat_width); end
        n = 0;
        while (fifo_count !== 3'd4 && n < 100) begin
            checks++; if (fifo_count !== 3'(mq.size())) begin errs++;
                $display("FAIL fill_count got %0d exp %0d", fifo_count, mq.size()); end
            tick(); n++;
        end
        checks++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL fill_timeout count=%0d exp 4", fifo_count); end
        for (int t = 0; t < 20; t++) begin
            tick();
            checks++; if (fifo_count !== 3'd4 || plat_dist !== 10'd90) begin errs++;
                $display("FAIL full_idle count=%0d dist=%0d exp 4/90", fifo_count, plat_dist); end
        end
    endtask

    task automatic test_max_reduce();
        rand_num = 10'd1023;
        do_reset();
        for (int t = 0; t <= 14; t++) begin
            if (t >= 13) begin
                checks++; if (plat_valid !== 1'(t == 14)) begin errs++;
                    $display("FAIL max_valid cycle=%0d got %b exp %b", t, plat_valid, (t == 14)); end
            end
            if (t < 14) tick();
        end
        checks++; if (plat_dist !== 10'd63 || plat_width !== 8'd44) begin errs++;
            $display("FAIL max_head got %0d/%0d exp 63/44", plat_dist, plat_width); end
    endtask

    task automatic test_full_pop();
        int   n;
        ent_t nxt;
        rand_num = 10'd300;
        do_reset();
        n = 0;
        while (!(mq.size() == DEPTH && m_left == 0 && !m_samp) && n < 400) begin
            rand_num = 10'($urandom_range(1, 1023));
            tick(); n++;
        end
        checks++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL fp_fill count=%0d exp 4", fifo_count); end
        // Head must hold steady while not accepted.
        for (int t = 0; t < 8; t++) begin
            rand_num = 10'($urandom_range(1, 1023));
            checks++; if ({plat_dist, plat_width} !== mq[0]) begin errs++;
                $display("FAIL fp_hold got %0d/%0d exp %0d/%0d", plat_dist, plat_width, mq[0].d, mq[0].w); end
            tick();
        end
        nxt = mq[1];
        plat_ready = 1'b1; tick(); plat_ready = 1'b0;
        checks++; if (fifo_count !== 3'd3) begin errs++; $display("FAIL fp_pop_count got %0d exp 3", fifo_count); end
        checks++; if ({plat_dist, plat_width} !== nxt) begin errs++;
            $display("FAIL fp_next got %0d/%0d exp %0d/%0d", plat_dist, plat_width, nxt.d, nxt.w); end
        n = 0;
        while (fifo_count !== 3'd4 && n < 40) begin
            rand_num = 10'($urandom_range(1, 1023));
            tick(); n++;
            checks++; if (fifo_count !== 3'(mq.size())) begin errs++;
                $display("FAIL fp_refill got %0d exp %0d", fifo_count, mq.size()); end
        end
        checks++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL fp_refill_timeout count=%0d", fifo_count); end
        plat_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            checks++; if ({plat_dist, plat_width} !== mq[0]) begin errs++;
                $display("FAIL fp_drain%0d got %0d/%0d exp %0d/%0d", t, plat_dist, plat_width, mq[0].d, mq[0].w); end
            tick();
        end
        plat_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int pops = 0;
        do_reset();
        plat_ready = 1'b1;
        for (int t = 0; t < 400; t++) begin
            rand_num = 10'($urandom);
            checks++; if (fifo_count !== 3'(mq.size()) || fifo_count > 3'd1) begin errs++;
                $display("FAIL b2b_count cycle=%0d got %0d exp %0d", t, fifo_count, mq.size()); end
            if (mq.size() != 0) begin
                pops++;
                checks++; if (plat_valid !== 1'b1 || {plat_dist, plat_width} !== mq[0]) begin errs++;
                    $display("FAIL b2b_head cycle=%0d got %b %0d/%0d exp %0d/%0d", t, plat_valid,
                             plat_dist, plat_width, mq[0].d, mq[0].w); end
            end
            tick();
        end
        checks++; if (pops < 20) begin errs++; $display("FAIL b2b_pops got %0d exp >=20", pops); end
        plat_ready = 1'b0;
    endtask

    task automatic test_clear();
        int n;
        do_reset();
        n = 0;
        while (!(mq.size() == 2 && m_left >= 3 && !m_samp) && n < 400) begin
            rand_num = 10'($urandom_range(500, 1023));
            tick(); n++;
        end
        checks++; if (fifo_count !== 3'd2) begin errs++; $display("FAIL clr_setup count=%0d exp 2", fifo_count); end
        clear = 1'b1; plat_ready = 1'b1; tick();
        clear = 1'b0; plat_ready = 1'b0;
        checks++; if (fifo_count !== 3'd0 || plat_valid !== 1'b0) begin errs++;
            $display("FAIL clr_flush count=%0d valid=%b exp 0/0", fifo_count, plat_valid); end
        rand_num = 10'($urandom_range(1, 1023));
        tick();
        rand_num = 10'd777;   // sampled in this cycle
        tick();
        for (int k = 2; k <= 11; k++) begin
            rand_num = 10'($urandom_range(1, 1023));
            checks++; if (plat_valid !== 1'(k == 11)) begin errs++;
                $display("FAIL clr_stale k=%0d valid=%b exp %b", k, plat_valid, (k == 11)); end
            if (k < 11) tick();
        end
        checks++; if (plat_dist !== 10'd117 || plat_width !== 8'd44) begin errs++;
            $display("FAIL clr_new got %0d/%0d exp 117/44", plat_dist, plat_width); end
    endtask

    task automatic test_stuck();
        rand_num = 10'd0;
        do_reset();
        for (int t = 0; t < 4; t++) tick();
        checks++; if (plat_valid !== 1'b1 || plat_dist !== 10'd40 || plat_width !== 8'd20) begin errs++;
            $display("FAIL stuck_head got %b %0d/%0d exp 1 40/20", plat_valid, plat_dist, plat_width); end
        checks++; if (lfsr_stuck !== 1'b1 || m_stuck !== 1'b1) begin errs++;
            $display("FAIL stuck_set got %b exp 1", lfsr_stuck); end
        rand_num = 10'd512;
        clear = 1'b1; tick(); clear = 1'b0;
        for (int t = 0; t < 10; t++) tick();
        checks++; if (lfsr_stuck !== 1'b1) begin errs++; $display("FAIL stuck_clear got %b exp 1", lfsr_stuck); end
        do_reset();
        checks++; if (lfsr_stuck !== 1'b0) begin errs++; $display("FAIL stuck_rst got %b exp 0", lfsr_stuck); end
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; plat_ready = 1'b0; rand_num = 10'd0;
        m_samp = 1'b0; m_left = 0; m_stuck = 1'b0; m_pend = '0;
        #1;
        test_reset();
        test_first_entry();
        test_max_reduce();
        test_full_pop();
        test_back_to_back();
        test_clear();
        test_stuck();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
